// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file widths, state encoding and constants
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
    localparam logic [REG_ADDR_W-1:0] LAST_REG = REG_ADDR_W'(NUM_REGS - 1);

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant with pointer flop
module rr_arbiter2 (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    // ptr names the requester preferred under contention
    logic ptr;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ptr <= 1'b0;
        end else if (accept) begin
            ptr <= grant[0];
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - shares the regfile write port between two requesters after a post-reset clear
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter bit          ENABLE_INIT = 1'b1,
    parameter logic [31:0] INIT_VALUE  = 32'd0,
    parameter int          COUNT_W     = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Req0Valid,
    output logic                  Req0Ready,
    input  logic [REG_ADDR_W-1:0] Req0Reg,
    input  logic [DATA_W-1:0]     Req0Data,
    input  logic                  Req1Valid,
    output logic                  Req1Ready,
    input  logic [REG_ADDR_W-1:0] Req1Reg,
    input  logic [DATA_W-1:0]     Req1Data,
    output logic [REG_ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0]     WriteData,
    output logic                  RegWrite,
    output logic                  InitDone,
    output logic [COUNT_W-1:0]    WriteCount
);

    state_t                  state, state_nxt;
    logic [REG_ADDR_W-1:0]   init_cnt;
    logic                    run;
    logic [1:0]              req;
    logic [1:0]              grant;
    logic                    accept;
    logic [REG_ADDR_W-1:0]   sel_reg;
    logic [DATA_W-1:0]       sel_data;

    assign run = (state == RUN);
    assign req = {Req1Valid & run, Req0Valid & run};

    rr_arbiter2 u_arb (
        .Clk    (Clk),
        .Reset  (Reset),
        .req    (req),
        .accept (accept),
        .grant  (grant)
    );

    // grant is only ever raised for a valid requester, so it doubles as the accept
    assign Req0Ready = grant[0];
    assign Req1Ready = grant[1];
    assign accept    = |grant;
    assign sel_reg   = grant[1] ? Req1Reg  : Req0Reg;
    assign sel_data  = grant[1] ? Req1Data : Req0Data;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= ENABLE_INIT ? INIT : RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == INIT && init_cnt == LAST_REG) begin
            state_nxt = RUN;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
            WriteCount    <= '0;
            InitDone      <= !ENABLE_INIT;
            init_cnt      <= REG_ADDR_W'(1);
        end else if (state == INIT) begin
            RegWrite      <= 1'b1;
            WriteRegister <= init_cnt;
            WriteData     <= INIT_VALUE;
            init_cnt      <= init_cnt + REG_ADDR_W'(1);
            if (init_cnt == LAST_REG) begin
                InitDone <= 1'b1;
            end
        end else if (accept) begin
            // r0 writes still consume the turn but never reach the regfile
            WriteRegister <= sel_reg;
            WriteData     <= sel_data;
            RegWrite      <= (sel_reg != ZERO_REG);
            if (sel_reg != ZERO_REG && WriteCount != {COUNT_W{1'b1}}) begin
                WriteCount <= WriteCount + COUNT_W'(1);
            end
        end else begin
            RegWrite <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed vector bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Req0Valid, Req1Valid;
    logic [4:0]  Req0Reg, Req1Reg;
    logic [31:0] Req0Data, Req1Data;
    logic        Req0Ready, Req1Ready;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        RegWrite, InitDone;
    logic [15:0] WriteCount;

    logic        b_v0, b_v1;
    logic [4:0]  b_r0, b_r1;
    logic [31:0] b_d0, b_d1;
    logic        b_rdy0, b_rdy1;
    logic [4:0]  b_wr;
    logic [31:0] b_wd;
    logic        b_rw, b_done;
    logic [1:0]  b_cnt;

    int passed = 0;
    int total  = 0;

    logic [31:0] rf [32];

    always #5 Clk = ~Clk;

    regfile_write_arbiter #(
        .ENABLE_INIT (1'b1),
        .INIT_VALUE  (32'hDEAD),
        .COUNT_W     (16)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Req0Valid     (Req0Valid),
        .Req0Ready     (Req0Ready),
        .Req0Reg       (Req0Reg),
        .Req0Data      (Req0Data),
        .Req1Valid     (Req1Valid),
        .Req1Ready     (Req1Ready),
        .Req1Reg       (Req1Reg),
        .Req1Data      (Req1Data),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .RegWrite      (RegWrite),
        .InitDone      (InitDone),
        .WriteCount    (WriteCount)
    );

    regfile_write_arbiter #(
        .ENABLE_INIT (1'b0),
        .INIT_VALUE  (32'd0),
        .COUNT_W     (2)
    ) dut_b (
        .Clk           (Clk),
        .Reset         (Reset),
        .Req0Valid     (b_v0),
        .Req0Ready     (b_rdy0),
        .Req0Reg       (b_r0),
        .Req0Data      (b_d0),
        .Req1Valid     (b_v1),
        .Req1Ready     (b_rdy1),
        .Req1Reg       (b_r1),
        .Req1Data      (b_d1),
        .WriteRegister (b_wr),
        .WriteData     (b_wd),
        .RegWrite      (b_rw),
        .InitDone      (b_done),
        .WriteCount    (b_cnt)
    );

    // Behavioural regfile: commits on posedge, r0 hardwired to zero
    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    end

    always @(posedge Clk) begin
        if (RegWrite && WriteRegister != 5'd0) rf[WriteRegister] <= WriteData;
    end

    typedef struct packed {
        logic        v0;
        logic [4:0]  r0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  r1;
        logic [31:0] d1;
        logic        rdy0;
        logic        rdy1;
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] wd;
        logic [15:0] cnt;
        logic [4:0]  creg;
        logic [31:0] cval;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic init_cycle(input int k, input logic exp_done);
        #1;
        check("init_rdy0", {31'd0, Req0Ready}, 32'd0);
        check("init_rdy1", {31'd0, Req1Ready}, 32'd0);
        @(posedge Clk);
        #1;
        check("init_rw",   {31'd0, RegWrite}, 32'd1);
        check("init_wr",   {27'd0, WriteRegister}, k);
        check("init_wd",   WriteData, 32'hDEAD);
        check("init_done", {31'd0, InitDone}, {31'd0, exp_done});
        @(negedge Clk);
    endtask

    initial begin
        //            v0  r0     d0        v1  r1     d1       rdy0 rdy1 rw  wr     wd         cnt  creg   cval
        tbl[0]  = '{1'b0, 5'd0,  32'd0,    1'b0, 5'd0,  32'd0,  1'b0, 1'b0, 1'b0, 5'd7,  32'h77,    16'd1, 5'd7,  32'h77};
        tbl[1]  = '{1'b0, 5'd0,  32'd0,    1'b1, 5'd0,  32'd15, 1'b0, 1'b1, 1'b0, 5'd0,  32'd15,    16'd1, 5'd0,  32'd0};
        tbl[2]  = '{1'b1, 5'd2,  32'd42,   1'b1, 5'd3,  32'd15, 1'b1, 1'b0, 1'b1, 5'd2,  32'd42,    16'd2, 5'd0,  32'd0};
        tbl[3]  = '{1'b1, 5'd2,  32'd42,   1'b1, 5'd3,  32'd15, 1'b0, 1'b1, 1'b1, 5'd3,  32'd15,    16'd3, 5'd2,  32'd42};
        tbl[4]  = '{1'b1, 5'd2,  32'd42,   1'b1, 5'd3,  32'd15, 1'b1, 1'b0, 1'b1, 5'd2,  32'd42,    16'd4, 5'd3,  32'd15};
        tbl[5]  = '{1'b1, 5'd2,  32'd42,   1'b1, 5'd3,  32'd15, 1'b0, 1'b1, 1'b1, 5'd3,  32'd15,    16'd5, 5'd2,  32'd42};
        tbl[6]  = '{1'b1, 5'd20, 32'd7,    1'b1, 5'd20, 32'd9,  1'b1, 1'b0, 1'b1, 5'd20, 32'd7,     16'd6, 5'd3,  32'd15};
        tbl[7]  = '{1'b0, 5'd0,  32'd0,    1'b1, 5'd20, 32'd9,  1'b0, 1'b1, 1'b1, 5'd20, 32'd9,     16'd7, 5'd20, 32'd7};
        tbl[8]  = '{1'b0, 5'd0,  32'd0,    1'b0, 5'd0,  32'd0,  1'b0, 1'b0, 1'b0, 5'd20, 32'd9,     16'd7, 5'd20, 32'd9};
        tbl[9]  = '{1'b0, 5'd0,  32'd0,    1'b1, 5'd5,  32'd1,  1'b0, 1'b1, 1'b1, 5'd5,  32'd1,     16'd8, 5'd5,  32'hDEAD};
        tbl[10] = '{1'b1, 5'd1,  32'hABC,  1'b0, 5'd0,  32'd0,  1'b1, 1'b0, 1'b1, 5'd1,  32'hABC,   16'd9, 5'd5,  32'd1};
        tbl[11] = '{1'b0, 5'd0,  32'd0,    1'b0, 5'd0,  32'd0,  1'b0, 1'b0, 1'b0, 5'd1,  32'hABC,   16'd9, 5'd1,  32'hABC};

        Reset = 1'b1;
        Req0Valid = 1'b1; Req0Reg = 5'd7; Req0Data = 32'h77;
        Req1Valid = 1'b0; Req1Reg = 5'd0; Req1Data = 32'd0;
        b_v0 = 1'b0; b_r0 = 5'd0; b_d0 = 32'd0;
        b_v1 = 1'b0; b_r1 = 5'd0; b_d1 = 32'd0;

        #1;
        check("rst_rw",     {31'd0, RegWrite}, 32'd0);
        check("rst_wr",     {27'd0, WriteRegister}, 32'd0);
        check("rst_wd",     WriteData, 32'd0);
        check("rst_cnt",    {16'd0, WriteCount}, 32'd0);
        check("rst_done",   {31'd0, InitDone}, 32'd0);
        check("rst_rdy0",   {31'd0, Req0Ready}, 32'd0);
        check("rst_b_done", {31'd0, b_done}, 32'd1);

        @(negedge Clk);
        Reset = 1'b0;
        for (int k = 1; k <= 10; k++) init_cycle(k, 1'b0);

        // asynchronous reset away from the active edge, mid-INIT
        Reset = 1'b1;
        #1;
        check("midrst_rw",   {31'd0, RegWrite}, 32'd0);
        check("midrst_wr",   {27'd0, WriteRegister}, 32'd0);
        check("midrst_wd",   WriteData, 32'd0);
        check("midrst_done", {31'd0, InitDone}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        for (int k = 1; k <= 31; k++) init_cycle(k, (k == 31));

        // first RUN cycle: the request held through INIT is accepted
        #1;
        check("run_rdy0", {31'd0, Req0Ready}, 32'd1);
        @(posedge Clk);
        #1;
        check("run_rw",  {31'd0, RegWrite}, 32'd1);
        check("run_wr",  {27'd0, WriteRegister}, 32'd7);
        check("run_wd",  WriteData, 32'h77);
        check("run_cnt", {16'd0, WriteCount}, 32'd1);
        check("rf_r31",  rf[31], 32'hDEAD);
        check("rf_r5",   rf[5], 32'hDEAD);
        check("rf_r0",   rf[0], 32'd0);
        @(negedge Clk);

        for (int i = 0; i < 12; i++) begin
            Req0Valid = tbl[i].v0; Req0Reg = tbl[i].r0; Req0Data = tbl[i].d0;
            Req1Valid = tbl[i].v1; Req1Reg = tbl[i].r1; Req1Data = tbl[i].d1;
            #1;
            check($sformatf("v%0d_rdy0", i), {31'd0, Req0Ready}, {31'd0, tbl[i].rdy0});
            check($sformatf("v%0d_rdy1", i), {31'd0, Req1Ready}, {31'd0, tbl[i].rdy1});
            @(posedge Clk);
            #1;
            check($sformatf("v%0d_rw", i),  {31'd0, RegWrite}, {31'd0, tbl[i].rw});
            check($sformatf("v%0d_wr", i),  {27'd0, WriteRegister}, {27'd0, tbl[i].wr});
            check($sformatf("v%0d_wd", i),  WriteData, tbl[i].wd);
            check($sformatf("v%0d_cnt", i), {16'd0, WriteCount}, {16'd0, tbl[i].cnt});
            check($sformatf("v%0d_rf", i),  rf[tbl[i].creg], tbl[i].cval);
            @(negedge Clk);
        end

        // no-init instance: immediate RUN and a saturating 2-bit counter
        for (int k = 1; k <= 4; k++) begin
            b_v0 = 1'b1; b_r0 = 5'd4; b_d0 = k;
            #1;
            check("b_rdy0", {31'd0, b_rdy0}, 32'd1);
            @(posedge Clk);
            #1;
            check("b_rw",  {31'd0, b_rw}, 32'd1);
            check("b_wd",  b_wd, k);
            check("b_cnt", {30'd0, b_cnt}, (k < 3) ? k : 3);
            @(negedge Clk);
        end
        b_v0 = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
